grad_wb_arbiter: RTL and testbench
==================================

# grad_wb_arbiter

Write-back arbiter sharing the single memory write port of the gradient system between two requesters: the high-magnitude bypass path and the accumulation-cache eviction path. It sits between those two producers and the `mem_address/mem_value/mem_valid/mem_ready` port. It registers the granted write, applies bypass-first priority with a bounded-burst anti-starvation rule, and sustains one write per cycle under continuous `mem_ready`.

## Interface
- `ADDR_WIDTH`, 32, write address width
- `GRAD_WIDTH`, 16, signed gradient width
- `MAX_BURST`, 4, max consecutive bypass grants while an eviction waits (1..15)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `byp_valid`  in  1  bypass request valid
- `byp_ready`  out  1  bypass request accepted this cycle
- `byp_address`  in  ADDR_WIDTH  bypass write address
- `byp_value`  in  GRAD_WIDTH signed  bypass write value
- `evc_valid`  in  1  eviction request valid
- `evc_ready`  out  1  eviction request accepted this cycle
- `evc_address`  in  ADDR_WIDTH  eviction write address
- `evc_value`  in  GRAD_WIDTH signed  eviction write value
- `mem_valid`  out  1  write pending on memory port
- `mem_ready`  in  1  memory accepts write
- `mem_address`  out  ADDR_WIDTH  write address
- `mem_value`  out  GRAD_WIDTH signed  write value
- `mem_src`  out  1  source of pending write (0 = bypass, 1 = eviction)

## Operation
- One output register `{mem_address, mem_value, mem_src}` plus its full flag (`mem_valid`).
- `load_en = !mem_valid || mem_ready`. A requester is accepted only when `load_en`.
- Selection when `load_en`:
  - If only one requester is valid, that requester wins.
  - If both are valid:
    - eviction wins when `burst_cnt == MAX_BURST`;
    - otherwise bypass wins.
- `byp_ready`/`evc_ready` are combinational: they are high exactly for the winner, never both. The winner's data loads on that edge.
- Requesters hold valid and data stable until accepted. Dropping valid before acceptance is a protocol violation; behaviour in that case is undefined.
- `burst_cnt` (4 bit) update rules:
  - Increments on a bypass grant while `evc_valid` = 1, saturating at `MAX_BURST`.
  - Clears on any eviction grant.
  - Clears on any cycle with `evc_valid` = 0.
- Drain only (`mem_valid && mem_ready`, no winner): `mem_valid` clears next edge.
- Drain and load on the same edge: the register reloads and `mem_valid` stays 1. Throughput is 1 write/cycle.
- `mem_ready` = 0 with `mem_valid` = 1: all mem outputs hold, and both readies are 0.
- Values pass through unmodified. No arithmetic and no address merging.

## Timing
- Latency: accept edge → `mem_valid` = 1 with that data in the following cycle (1 cycle).
- Reset values: `mem_valid` 0, `mem_address` 0, `mem_value` 0, `mem_src` 0, `burst_cnt` 0. Ready outputs follow combinationally from the reset state (1 for the winner if valid, since the register is empty).
- Reset asserted mid-operation discards the held write immediately (asynchronous). No write is replayed.
- Worst-case eviction wait under saturated bypass traffic with `mem_ready` = 1: `MAX_BURST` + 1 grants.

## Configuration
- `GRAD_ARB_STATS_EN` defined: adds the following outputs.
  - `stat_byp_grants` (32 bit) and `stat_evc_grants` (32 bit): increment on the respective grant.
  - `stat_stall_cycles` (32 bit): counts cycles with `mem_valid && !mem_ready`.
  - All three saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Package `grad_wb_pkg`:
  - `typedef enum logic {SRC_BYP = 1'b0, SRC_EVC = 1'b1} wb_src_e`;
  - packed struct `wb_req_t {addr, value}`, parameterised via package localparams `WB_ADDR_W` = 32 and `WB_GRAD_W` = 16;
  - `localparam STAT_W = 32`.
- Sub-module `grad_wb_stats` holds the three saturating counters. It is instantiated only under `GRAD_ARB_STATS_EN`.

## Test plan
- Bypass only, `mem_ready` = 1: 8 writes to 0x1000..0x1007, value 100 → 8 consecutive `mem_valid` cycles, first one cycle after first accept, `mem_src` = 0, order preserved.
- Both valid continuously, `MAX_BURST` = 4, `mem_ready` = 1 → grant pattern B,B,B,B,E repeating. `evc_ready` is never low for more than 4 consecutive cycles while `evc_valid`.
- Backpressure: `mem_ready` = 0 for 5 cycles with a write held (0x200, −15) → outputs stable, both readies 0. On `mem_ready` = 1, the next request loads on the same edge and `mem_valid` stays high.
- Eviction only, `mem_ready` toggling 1,0,1,0: 4 evictions 0x50/0x150/0x250/0x350, value 40 → each delivered exactly once, `mem_src` = 1, no loss or duplication.
- Reset asserted mid-stream while `mem_valid` = 1 → `mem_valid` drops without a clock edge, all outputs 0, `burst_cnt` 0, and the first post-reset grant goes to bypass if both valid.
- With `GRAD_ARB_STATS_EN`: 10 bypass, 3 eviction, 7 stall cycles → `stat_byp_grants` = 10, `stat_evc_grants` = 3, `stat_stall_cycles` = 7.

Source files
------------

// File: rtl/grad_wb_pkg.sv
// Shared types and widths for the gradient write-back arbiter.
package grad_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_GRAD_W = 16;
    localparam int STAT_W    = 32;

    typedef enum logic {
        SRC_BYP = 1'b0,
        SRC_EVC = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic        [WB_ADDR_W-1:0] addr;
        logic signed [WB_GRAD_W-1:0] value;
    } wb_req_t;

endpackage

// File: rtl/grad_wb_stats.sv
// Saturating event counters for the write-back arbiter: grants per source
// and cycles where a pending write is blocked by the memory port.
module grad_wb_stats
    import grad_wb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              byp_grant,
    input  logic              evc_grant,
    input  logic              stall,
    output logic [STAT_W-1:0] stat_byp_grants,
    output logic [STAT_W-1:0] stat_evc_grants,
    output logic [STAT_W-1:0] stat_stall_cycles
);

    // Count bypass grants, holding at all-ones instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_byp_grants <= '0;
        end else if (byp_grant && (stat_byp_grants != '1)) begin
            stat_byp_grants <= stat_byp_grants + 1'b1;
        end
    end

    // Count eviction grants, holding at all-ones instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_evc_grants <= '0;
        end else if (evc_grant && (stat_evc_grants != '1)) begin
            stat_evc_grants <= stat_evc_grants + 1'b1;
        end
    end

    // Count cycles where a write waits on memory, holding at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_stall_cycles <= '0;
        end else if (stall && (stat_stall_cycles != '1)) begin
            stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end

endmodule

// File: rtl/grad_wb_arbiter.sv
// Write-back arbiter: shares the single memory write port between the
// high-magnitude bypass path and the accumulation-cache eviction path.
// Bypass has priority, but after MAX_BURST bypass grants with an eviction
// waiting, the eviction is forced through. One registered output stage.
// Optional build macro GRAD_ARB_STATS_EN adds saturating statistic outputs.
module grad_wb_arbiter
    import grad_wb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          GRAD_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         byp_valid,
    output logic                         byp_ready,
    input  logic        [ADDR_WIDTH-1:0] byp_address,
    input  logic signed [GRAD_WIDTH-1:0] byp_value,
    input  logic                         evc_valid,
    output logic                         evc_ready,
    input  logic        [ADDR_WIDTH-1:0] evc_address,
    input  logic signed [GRAD_WIDTH-1:0] evc_value,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic        [ADDR_WIDTH-1:0] mem_address,
    output logic signed [GRAD_WIDTH-1:0] mem_value,
    output logic                         mem_src
`ifdef GRAD_ARB_STATS_EN
    ,
    output logic        [STAT_W-1:0]     stat_byp_grants,
    output logic        [STAT_W-1:0]     stat_evc_grants,
    output logic        [STAT_W-1:0]     stat_stall_cycles
`endif
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    logic       load_en;
    logic       grant_byp;
    logic       grant_evc;
    logic [3:0] burst_cnt;
    wb_src_e    src_q;

    // Pick at most one winner; the register can take data when empty or draining
    always_comb begin
        load_en   = !mem_valid || mem_ready;
        grant_evc = 1'b0;
        grant_byp = 1'b0;
        if (load_en) begin
            if (evc_valid && (!byp_valid || (burst_cnt == MAX_BURST_C))) begin
                grant_evc = 1'b1;
            end else if (byp_valid) begin
                grant_byp = 1'b1;
            end
        end
    end

    assign byp_ready = grant_byp;
    assign evc_ready = grant_evc;
    assign mem_src   = src_q;

    // Track consecutive bypass wins while an eviction is waiting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (!evc_valid || grant_evc) begin
            burst_cnt <= '0;
        end else if (grant_byp && (burst_cnt != MAX_BURST_C)) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    // Output register: load the winner, otherwise empty once memory takes the write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            mem_address <= '0;
            mem_value   <= '0;
            src_q       <= SRC_BYP;
        end else if (grant_byp) begin
            mem_valid   <= 1'b1;
            mem_address <= byp_address;
            mem_value   <= byp_value;
            src_q       <= SRC_BYP;
        end else if (grant_evc) begin
            mem_valid   <= 1'b1;
            mem_address <= evc_address;
            mem_value   <= evc_value;
            src_q       <= SRC_EVC;
        end else if (mem_ready) begin
            mem_valid   <= 1'b0;
        end
    end

`ifdef GRAD_ARB_STATS_EN
    grad_wb_stats u_stats (
        .clock             (clock),
        .reset             (reset),
        .byp_grant         (grant_byp),
        .evc_grant         (grant_evc),
        .stall             (mem_valid && !mem_ready),
        .stat_byp_grants   (stat_byp_grants),
        .stat_evc_grants   (stat_evc_grants),
        .stat_stall_cycles (stat_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_grad_wb_arbiter.sv
// Testbench for grad_wb_arbiter: a cycle model predicts grants and pushes
// each accepted write into a scoreboard queue; writes are popped and
// compared as the DUT presents them on the memory port.
module tb_grad_wb_arbiter;
    import grad_wb_pkg::*;

    localparam int ADDR_WIDTH = 32;
    localparam int GRAD_WIDTH = 16;
    localparam int MAX_BURST  = 4;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         byp_valid = 1'b0;
    logic                         byp_ready;
    logic        [ADDR_WIDTH-1:0] byp_address = '0;
    logic signed [GRAD_WIDTH-1:0] byp_value = '0;
    logic                         evc_valid = 1'b0;
    logic                         evc_ready;
    logic        [ADDR_WIDTH-1:0] evc_address = '0;
    logic signed [GRAD_WIDTH-1:0] evc_value = '0;
    logic                         mem_valid;
    logic                         mem_ready = 1'b1;
    logic        [ADDR_WIDTH-1:0] mem_address;
    logic signed [GRAD_WIDTH-1:0] mem_value;
    logic                         mem_src;
`ifdef GRAD_ARB_STATS_EN
    logic [STAT_W-1:0] stat_byp_grants;
    logic [STAT_W-1:0] stat_evc_grants;
    logic [STAT_W-1:0] stat_stall_cycles;
`endif

    grad_wb_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .GRAD_WIDTH (GRAD_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .byp_valid   (byp_valid),
        .byp_ready   (byp_ready),
        .byp_address (byp_address),
        .byp_value   (byp_value),
        .evc_valid   (evc_valid),
        .evc_ready   (evc_ready),
        .evc_address (evc_address),
        .evc_value   (evc_value),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_address (mem_address),
        .mem_value   (mem_value),
        .mem_src     (mem_src)
`ifdef GRAD_ARB_STATS_EN
        ,
        .stat_byp_grants   (stat_byp_grants),
        .stat_evc_grants   (stat_evc_grants),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        wb_req_t req;
        logic    src;
    } sb_t;

    sb_t  sb_q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   n_drained = 0;
    bit   m_valid = 1'b0;
    int   m_burst = 0;
    bit   g_byp;
    bit   g_evc;
    logic obs_byp_ready;
    logic obs_evc_ready;

    // One clock cycle: entered just after a falling edge with inputs driven,
    // checks the DUT against the model, then returns at the next falling edge
    task automatic tick();
        bit  load;
        bit  ge;
        bit  gb;
        sb_t exp_item;
        sb_t act_item;
        #1;
        load = !m_valid || mem_ready;
        ge   = load && evc_valid && (!byp_valid || (m_burst == MAX_BURST));
        gb   = load && byp_valid && !ge;
        obs_byp_ready = byp_ready;
        obs_evc_ready = evc_ready;
        n_compared++;
        if ((byp_ready !== gb) || (evc_ready !== ge)) begin
            n_mismatched++;
            $display("[TB] FAIL readies: got byp=%b evc=%b, want byp=%b evc=%b at %0t",
                     byp_ready, evc_ready, gb, ge, $time);
        end
        n_compared++;
        if (mem_valid !== m_valid) begin
            n_mismatched++;
            $display("[TB] FAIL mem_valid: got %b, want %b at %0t", mem_valid, m_valid, $time);
        end
        if (m_valid) begin
            n_compared++;
            if (sb_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL scoreboard_empty: got write addr=%h, want none at %0t",
                         mem_address, $time);
            end else begin
                exp_item = sb_q[0];
                act_item = {mem_address, mem_value, mem_src};
                if (act_item !== exp_item) begin
                    n_mismatched++;
                    $display("[TB] FAIL mem_write: got addr=%h val=%0d src=%b, want addr=%h val=%0d src=%b at %0t",
                             mem_address, mem_value, mem_src, exp_item.req.addr,
                             exp_item.req.value, exp_item.src, $time);
                end
                if (mem_ready) begin
                    void'(sb_q.pop_front());
                    n_drained++;
                end
            end
        end
        if (gb) sb_q.push_back({byp_address, byp_value, 1'b0});
        if (ge) sb_q.push_back({evc_address, evc_value, 1'b1});
        if (gb || ge)      m_valid = 1'b1;
        else if (mem_ready) m_valid = 1'b0;
        if (!evc_valid || ge)                  m_burst = 0;
        else if (gb && (m_burst != MAX_BURST)) m_burst = m_burst + 1;
        g_byp = gb;
        g_evc = ge;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drop all requests and let the output register drain
    task automatic go_idle();
        byp_valid = 1'b0;
        evc_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
    endtask

    // Pulse reset between falling edges and restart the model
    task automatic pulse_reset();
        reset = 1'b1;
        sb_q.delete();
        m_valid = 1'b0;
        m_burst = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Outputs are cleared in reset, and readies already reflect the empty register
    task automatic test_reset();
        byp_valid = 1'b1;
        evc_valid = 1'b0;
        #1;
        n_compared++;
        if ({mem_valid, mem_address, mem_value, mem_src} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got v=%b a=%h d=%0d s=%b, want all 0",
                     mem_valid, mem_address, mem_value, mem_src);
        end
        n_compared++;
        if ((byp_ready !== 1'b1) || (evc_ready !== 1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL reset_readies: got byp=%b evc=%b, want 1 0", byp_ready, evc_ready);
        end
        byp_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    // Eight bypass writes stream out at one per cycle in order
    task automatic test_bypass_only();
        int accepted = 0;
        int drained0 = n_drained;
        mem_ready   = 1'b1;
        byp_valid   = 1'b1;
        byp_address = 32'h1000;
        byp_value   = 16'sd100;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (g_byp) begin
                accepted++;
                byp_address = 32'h1000 + 32'(accepted);
                if (accepted == 8) byp_valid = 1'b0;
            end
        end
        n_compared++;
        if (accepted != 8) begin
            n_mismatched++;
            $display("[TB] FAIL bypass_accepts: got %0d in 8 cycles, want 8", accepted);
        end
        tick();
        tick();
        n_compared++;
        if ((n_drained - drained0) != 8) begin
            n_mismatched++;
            $display("[TB] FAIL bypass_drained: got %0d, want 8", n_drained - drained0);
        end
    endtask

    // Both requesters saturated: grants follow B,B,B,B,E repeating
    task automatic test_burst_limit();
        int low_run = 0;
        int max_low = 0;
        logic want_evc;
        mem_ready   = 1'b1;
        byp_valid   = 1'b1;
        evc_valid   = 1'b1;
        byp_address = 32'h2000;
        evc_address = 32'h3000;
        byp_value   = 16'sd5;
        evc_value   = -16'sd5;
        for (int k = 0; k < 20; k++) begin
            want_evc = ((k % 5) == 4);
            tick();
            n_compared++;
            if ((obs_evc_ready !== want_evc) || (obs_byp_ready !== !want_evc)) begin
                n_mismatched++;
                $display("[TB] FAIL burst_pattern[%0d]: got byp=%b evc=%b, want evc=%b",
                         k, obs_byp_ready, obs_evc_ready, want_evc);
            end
            if (obs_evc_ready === 1'b1) low_run = 0;
            else                       low_run++;
            if (low_run > max_low) max_low = low_run;
            if (g_byp) byp_address = byp_address + 32'd1;
            if (g_evc) evc_address = evc_address + 32'd1;
        end
        n_compared++;
        if (max_low > MAX_BURST) begin
            n_mismatched++;
            $display("[TB] FAIL evc_starvation: got %0d waiting cycles, want <= %0d", max_low, MAX_BURST);
        end
        go_idle();
    endtask

    // A held write stays put under backpressure, then drain and load share an edge
    task automatic test_backpressure();
        int budget = 0;
        mem_ready   = 1'b1;
        byp_valid   = 1'b1;
        byp_address = 32'h200;
        byp_value   = -16'sd15;
        tick();
        byp_address = 32'h300;
        byp_value   = 16'sd7;
        evc_valid   = 1'b1;
        evc_address = 32'h400;
        evc_value   = 16'sd9;
        mem_ready   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_compared++;
            if ((mem_address !== 32'h200) || (mem_value !== -16'sd15) || (mem_valid !== 1'b1) ||
                (obs_byp_ready !== 1'b0) || (obs_evc_ready !== 1'b0)) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b a=%h d=%0d rdy=%b%b, want v=1 a=200 d=-15 rdy=00",
                         k, mem_valid, mem_address, mem_value, obs_byp_ready, obs_evc_ready);
            end
        end
        mem_ready = 1'b1;
        tick();
        n_compared++;
        if ((obs_byp_ready !== 1'b1) || (mem_valid !== 1'b1) || (mem_address !== 32'h300)) begin
            n_mismatched++;
            $display("[TB] FAIL drain_and_load: got byp_ready=%b v=%b a=%h, want 1 1 300",
                     obs_byp_ready, mem_valid, mem_address);
        end
        byp_valid = 1'b0;
        g_evc = 1'b0;
        while (!g_evc && (budget < 10)) begin
            tick();
            budget++;
        end
        if (!g_evc) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL evc_after_stall: got no grant in 10 cycles, want grant");
        end
        go_idle();
    endtask

    // Evictions under toggling mem_ready are each delivered exactly once
    task automatic test_evict_only();
        int accepted = 0;
        int drained0 = n_drained;
        int k = 0;
        byp_valid   = 1'b0;
        evc_valid   = 1'b1;
        evc_address = 32'h50;
        evc_value   = 16'sd40;
        while (((n_drained - drained0) < 4) && (k < 40)) begin
            mem_ready = ((k % 2) == 0);
            tick();
            if (g_evc) begin
                accepted++;
                evc_address = 32'h50 + 32'(accepted) * 32'h100;
                if (accepted == 4) evc_valid = 1'b0;
            end
            k++;
        end
        n_compared++;
        if (((n_drained - drained0) != 4) || (accepted != 4)) begin
            n_mismatched++;
            $display("[TB] FAIL evict_delivery: got %0d accepted %0d drained, want 4 4",
                     accepted, n_drained - drained0);
        end
        go_idle();
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL evict_leftover: got %0d queued, want 0", sb_q.size());
        end
    endtask

    // Asynchronous reset mid-stream clears outputs at once; bypass wins first after
    task automatic test_reset_midstream();
        mem_ready   = 1'b1;
        byp_valid   = 1'b1;
        evc_valid   = 1'b1;
        byp_address = 32'h7000;
        evc_address = 32'h8000;
        byp_value   = 16'sd3;
        evc_value   = 16'sd4;
        for (int k = 0; k < 3; k++) tick();
        #3;
        reset = 1'b1;
        #1;
        n_compared++;
        if ({mem_valid, mem_address, mem_value, mem_src} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset_outputs: got v=%b a=%h d=%0d s=%b, want all 0",
                     mem_valid, mem_address, mem_value, mem_src);
        end
        n_compared++;
        if (dut.burst_cnt !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset_burst: got %0d, want 0", dut.burst_cnt);
        end
        sb_q.delete();
        m_valid = 1'b0;
        m_burst = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        n_compared++;
        if ((obs_byp_ready !== 1'b1) || (obs_evc_ready !== 1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_grant: got byp=%b evc=%b, want 1 0", obs_byp_ready, obs_evc_ready);
        end
        byp_valid = 1'b0;
        g_evc = 1'b0;
        for (int k = 0; k < 10 && !g_evc; k++) tick();
        go_idle();
    endtask

`ifdef GRAD_ARB_STATS_EN
    // Statistic counters track grants and stalled cycles
    task automatic test_stats();
        int accepted = 0;
        int k = 0;
        pulse_reset();
        mem_ready   = 1'b1;
        byp_valid   = 1'b1;
        byp_address = 32'hA000;
        byp_value   = 16'sd1;
        while ((accepted < 10) && (k < 40)) begin
            tick();
            if (g_byp) begin
                accepted++;
                byp_address = byp_address + 32'd1;
            end
            k++;
        end
        byp_valid   = 1'b0;
        evc_valid   = 1'b1;
        evc_address = 32'hB000;
        evc_value   = 16'sd2;
        accepted = 0;
        k = 0;
        while ((accepted < 3) && (k < 40)) begin
            if (accepted == 2) begin
                tick();
                if (g_evc) accepted++;
                evc_valid = accepted == 3 ? 1'b0 : 1'b1;
            end else begin
                tick();
                if (g_evc) begin
                    accepted++;
                    evc_address = evc_address + 32'd1;
                end
            end
            k++;
        end
        evc_valid = 1'b0;
        mem_ready = 1'b0;
        for (int j = 0; j < 7; j++) tick();
        mem_ready = 1'b1;
        tick();
        n_compared++;
        if ((stat_byp_grants !== 32'd10) || (stat_evc_grants !== 32'd3) || (stat_stall_cycles !== 32'd7)) begin
            n_mismatched++;
            $display("[TB] FAIL stats: got byp=%0d evc=%0d stall=%0d, want 10 3 7",
                     stat_byp_grants, stat_evc_grants, stat_stall_cycles);
        end
        go_idle();
    endtask
`endif

    initial begin
        @(negedge clock);
        test_reset();
        test_bypass_only();
        test_burst_limit();
        test_backpressure();
        test_evict_only();
        test_reset_midstream();
`ifdef GRAD_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
